// File: rtl/set_assoc_cache_ctrl.sv
// rtl/set_assoc_cache_ctrl.sv - set-associative write-back cache controller with tree-PLRU replacement
// Optional hit/miss counters (hit_count/miss_count ports) are built only with CACHE_PERF_COUNTERS_EN defined.
module set_assoc_cache_ctrl #(
  parameter int ADDR_SIZE   = 32,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic [ADDR_SIZE-1:0]        cpu_req_addr,
  input  logic                        cpu_req_write,
  output logic                        cpu_resp_valid,
  output logic                        cpu_resp_hit,
  output logic [$clog2(NUM_SETS)-1:0] data_set,
  output logic [$clog2(NUM_WAYS)-1:0] data_way,
  output logic                        data_we,
  output logic                        refill_we,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_write,
  output logic [ADDR_SIZE-1:0]        mem_req_addr,
  input  logic                        mem_resp_valid
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0]        hit_count,
  output logic [CNT_WIDTH-1:0]        miss_count
`endif
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_SIZE - SET_W - OFF_W;
  localparam int BLK_W = ADDR_SIZE - OFF_W;
  localparam int NODES = NUM_WAYS - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_WB_REQ  = 3'd2;
  localparam logic [2:0] S_WB_WAIT = 3'd3;
  localparam logic [2:0] S_RF_REQ  = 3'd4;
  localparam logic [2:0] S_RF_WAIT = 3'd5;
  localparam logic [2:0] S_RESPOND = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic                write_q, write_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [TAG_W-1:0]    tag_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_d [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [NODES-1:0]    plru_q [NUM_SETS];
  logic [NODES-1:0]    plru_d [NUM_SETS];

  logic [SET_W-1:0]    req_set;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    miss_victim;

  assign req_set  = blk_q[SET_W-1:0];
  assign req_tag  = blk_q[BLK_W-1:SET_W];
  assign data_set = req_set;

  // Tree nodes are heap-ordered: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [WAY_W-1:0] plru_pick(input logic [NODES-1:0] bits);
    int node;
    logic b;
    logic [WAY_W-1:0] way;
    node = 0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = bits[node];
      way  = (way << 1) | WAY_W'(b);
      node = 2 * node + 1 + int'(b);
    end
    return way;
  endfunction

  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    int node;
    logic b;
    logic [NODES-1:0] res;
    res  = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b         = way[WAY_W-1-l];
      res[node] = ~b;
      node      = 2 * node + 1 + int'(b);
    end
    return res;
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    miss_victim = inv_found ? inv_way : plru_pick(plru_q[req_set]);
  end

  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    write_d        = write_q;
    victim_d       = victim_q;
    tag_d          = tag_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    plru_d         = plru_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_hit   = 1'b0;
    data_way       = '0;
    data_we        = 1'b0;
    refill_we      = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_req_addr   = '0;
    case (state_q)
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          blk_d   = cpu_req_addr[ADDR_SIZE-1:OFF_W];
          write_d = cpu_req_write;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_resp_valid  = 1'b1;
          cpu_resp_hit    = 1'b1;
          data_way        = hit_way;
          data_we         = write_q;
          if (write_q) dirty_d[req_set][hit_way] = 1'b1;
          plru_d[req_set] = plru_touch(plru_q[req_set], hit_way);
          state_d         = S_IDLE;
        end else begin
          victim_d = miss_victim;
          state_d  = (valid_q[req_set][miss_victim] && dirty_q[req_set][miss_victim])
                     ? S_WB_REQ : S_RF_REQ;
        end
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[req_set][victim_q], req_set, {OFF_W{1'b0}}};
        data_way      = victim_q;
        if (mem_req_ready) state_d = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        data_way = victim_q;
        if (mem_resp_valid) begin
          dirty_d[req_set][victim_q] = 1'b0;
          state_d                    = S_RF_REQ;
        end
      end
      S_RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {blk_q, {OFF_W{1'b0}}};
        data_way      = victim_q;
        if (mem_req_ready) state_d = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        data_way = victim_q;
        if (mem_resp_valid) begin
          refill_we                  = 1'b1;
          tag_d[req_set][victim_q]   = req_tag;
          valid_d[req_set][victim_q] = 1'b1;
          dirty_d[req_set][victim_q] = 1'b0;
          plru_d[req_set]            = plru_touch(plru_q[req_set], victim_q);
          state_d                    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        cpu_resp_valid = 1'b1;
        data_way       = victim_q;
        data_we        = write_q;
        if (write_q) dirty_d[req_set][victim_q] = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      blk_q    <= '0;
      write_q  <= 1'b0;
      victim_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      write_q  <= write_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      plru_q   <= plru_d;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

`ifdef CACHE_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP) begin
      if (hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
      if (!hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
